// File: rtl/calc1_defs_pkg.sv
// Shared definitions for the calc1 scheduler: command encodings, the
// unit-select decode and the response codes used by the output stage.
package calc1_defs_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Response codes consumed by the output stage.
  localparam logic [1:0] RSP_OK  = 2'b01;
  localparam logic [1:0] RSP_INV = 2'b10;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_ALU1 = 2'd1,
    UNIT_ALU2 = 2'd2,
    UNIT_INV  = 2'd3
  } unit_e;

  // Maps a command onto the unit that must service it.
  function automatic unit_e unit_sel(input logic [3:0] cmd);
    unit_e u;
    case (cmd)
      CMD_NOP:          u = UNIT_NONE;
      CMD_ADD, CMD_SUB: u = UNIT_ALU1;
      CMD_SHL, CMD_SHR: u = UNIT_ALU2;
      default:          u = UNIT_INV;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/calc1_rr_arb.sv
// Four-way round-robin arbiter. The pointer names the port with highest
// priority; after a grant it moves to the port following the winner.
module calc1_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic       gnt_vld_o,
  output logic [1:0] gnt_id_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [3:0] rot;
  logic [1:0] off;
  logic       hit;

  // Rotate requests so the pointer port sits at bit 0, then pick the lowest set bit.
  always_comb begin
    rot = 4'({req_i, req_i} >> ptr_q);
    hit = 1'b1;
    off = 2'd0;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: hit = 1'b0;
    endcase
    gnt_vld_o = hit;
    gnt_id_o  = hit ? (ptr_q + off) : 2'd0;
    gnt_o     = hit ? (4'b0001 << gnt_id_o) : 4'b0000;
    ptr_d     = hit ? (gnt_id_o + 2'd1) : ptr_q;
  end

  // Pointer register: follows the last winner, back to port 1 on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/calc1_dispatch_sched.sv
// calc1 command scheduler: arbitrates four requester ports onto the adder
// and shifter, answers invalid commands, and tracks in-flight operations
// through fixed-latency valid/ID pipelines.
module calc1_dispatch_sched
  import calc1_defs_pkg::*;
#(
  parameter int ADD_LAT = 3,
  parameter int SHF_LAT = 3
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic [3:0] req1_cmd_in,
  input  logic [3:0] req2_cmd_in,
  input  logic [3:0] req3_cmd_in,
  input  logic [3:0] req4_cmd_in,
  output logic       prio_req1_ack,
  output logic       prio_req2_ack,
  output logic       prio_req3_ack,
  output logic       prio_req4_ack,
  output logic [3:0] prio_alu1_in_cmd,
  output logic [1:0] prio_alu1_in_req_id,
  output logic       prio_alu1_out_vld,
  output logic [1:0] prio_alu1_out_req_id,
  output logic [3:0] prio_alu2_in_cmd,
  output logic [1:0] prio_alu2_in_req_id,
  output logic       prio_alu2_out_vld,
  output logic [1:0] prio_alu2_out_req_id,
  output logic       prio_inv_vld,
  output logic [1:0] prio_inv_req_id
);

  logic [3:0] cmd [4];
  logic [3:0] ack_q, ack_d;
  logic [3:0] alu1_req, alu2_req, inv_req;
  logic [3:0] alu1_gnt, alu2_gnt, inv_gnt;
  logic       alu1_hit, alu2_hit, inv_hit;
  logic [1:0] alu1_id, alu2_id, inv_id;

  logic [3:0] alu1_cmd_q, alu1_cmd_d;
  logic [3:0] alu2_cmd_q, alu2_cmd_d;
  logic [1:0] alu1_id_q, alu1_id_d;
  logic [1:0] alu2_id_q, alu2_id_d;
  logic       inv_vld_q, inv_vld_d;
  logic [1:0] inv_id_q, inv_id_d;

  logic [ADD_LAT-1:0] a1_vld_q;
  logic [1:0]         a1_id_q [ADD_LAT];
  logic [SHF_LAT-1:0] a2_vld_q;
  logic [1:0]         a2_id_q [SHF_LAT];

  assign cmd[0] = req1_cmd_in;
  assign cmd[1] = req2_cmd_in;
  assign cmd[2] = req3_cmd_in;
  assign cmd[3] = req4_cmd_in;

  // Decode each port; a port just acked is masked so its stale command is not re-granted.
  always_comb begin
    alu1_req = 4'b0000;
    alu2_req = 4'b0000;
    inv_req  = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      case (unit_sel(cmd[p]))
        UNIT_ALU1: alu1_req[p] = !ack_q[p];
        UNIT_ALU2: alu2_req[p] = !ack_q[p];
        UNIT_INV:  inv_req[p]  = !ack_q[p];
        default:   ;
      endcase
    end
  end

  calc1_rr_arb u_arb_alu1 (
    .clk_i     (c_clk),
    .rst_ni    (reset),
    .req_i     (alu1_req),
    .gnt_o     (alu1_gnt),
    .gnt_vld_o (alu1_hit),
    .gnt_id_o  (alu1_id)
  );

  calc1_rr_arb u_arb_alu2 (
    .clk_i     (c_clk),
    .rst_ni    (reset),
    .req_i     (alu2_req),
    .gnt_o     (alu2_gnt),
    .gnt_vld_o (alu2_hit),
    .gnt_id_o  (alu2_id)
  );

  // Invalid commands are answered one per cycle, lowest port first.
  always_comb begin
    inv_hit = 1'b1;
    inv_id  = 2'd0;
    casez (inv_req)
      4'b???1: inv_id = 2'd0;
      4'b??10: inv_id = 2'd1;
      4'b?100: inv_id = 2'd2;
      4'b1000: inv_id = 2'd3;
      default: inv_hit = 1'b0;
    endcase
    inv_gnt = inv_hit ? (4'b0001 << inv_id) : 4'b0000;
  end

  // Next grant outputs: unit commands are forced to NOP when the unit is idle.
  always_comb begin
    ack_d      = alu1_gnt | alu2_gnt | inv_gnt;
    alu1_cmd_d = alu1_hit ? cmd[alu1_id] : CMD_NOP;
    alu1_id_d  = alu1_id;
    alu2_cmd_d = alu2_hit ? cmd[alu2_id] : CMD_NOP;
    alu2_id_d  = alu2_id;
    inv_vld_d  = inv_hit;
    inv_id_d   = inv_id;
  end

  // Grant registers: every grant output is high for exactly one cycle.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      ack_q      <= 4'b0000;
      alu1_cmd_q <= CMD_NOP;
      alu1_id_q  <= 2'd0;
      alu2_cmd_q <= CMD_NOP;
      alu2_id_q  <= 2'd0;
      inv_vld_q  <= 1'b0;
      inv_id_q   <= 2'd0;
    end else begin
      ack_q      <= ack_d;
      alu1_cmd_q <= alu1_cmd_d;
      alu1_id_q  <= alu1_id_d;
      alu2_cmd_q <= alu2_cmd_d;
      alu2_id_q  <= alu2_id_d;
      inv_vld_q  <= inv_vld_d;
      inv_id_q   <= inv_id_d;
    end
  end

  // Adder tracking pipeline: a dispatch seen in C1 leaves the last stage in C1+ADD_LAT.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      a1_vld_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) a1_id_q[i] <= 2'd0;
    end else begin
      a1_vld_q[0] <= (alu1_cmd_q != CMD_NOP);
      a1_id_q[0]  <= alu1_id_q;
      for (int i = 1; i < ADD_LAT; i++) begin
        a1_vld_q[i] <= a1_vld_q[i-1];
        a1_id_q[i]  <= a1_id_q[i-1];
      end
    end
  end

  // Shifter tracking pipeline: same structure, SHF_LAT stages.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      a2_vld_q <= '0;
      for (int i = 0; i < SHF_LAT; i++) a2_id_q[i] <= 2'd0;
    end else begin
      a2_vld_q[0] <= (alu2_cmd_q != CMD_NOP);
      a2_id_q[0]  <= alu2_id_q;
      for (int i = 1; i < SHF_LAT; i++) begin
        a2_vld_q[i] <= a2_vld_q[i-1];
        a2_id_q[i]  <= a2_id_q[i-1];
      end
    end
  end

  assign prio_req1_ack        = ack_q[0];
  assign prio_req2_ack        = ack_q[1];
  assign prio_req3_ack        = ack_q[2];
  assign prio_req4_ack        = ack_q[3];
  assign prio_alu1_in_cmd     = alu1_cmd_q;
  assign prio_alu1_in_req_id  = alu1_id_q;
  assign prio_alu2_in_cmd     = alu2_cmd_q;
  assign prio_alu2_in_req_id  = alu2_id_q;
  assign prio_alu1_out_vld    = a1_vld_q[ADD_LAT-1];
  assign prio_alu1_out_req_id = a1_id_q[ADD_LAT-1];
  assign prio_alu2_out_vld    = a2_vld_q[SHF_LAT-1];
  assign prio_alu2_out_req_id = a2_id_q[SHF_LAT-1];
  assign prio_inv_vld         = inv_vld_q;
  assign prio_inv_req_id      = inv_id_q;

endmodule

// File: tb/tb_calc1_dispatch_sched.sv
// Self-checking bench for calc1_dispatch_sched. Two instances share the
// stimulus: default latencies (3/3) and ADD_LAT=1 / SHF_LAT=8. Expected
// results are queued when stimulus is driven and compared as they appear.
module tb_calc1_dispatch_sched;

  localparam int D_ADD = 3;
  localparam int D_SHF = 3;
  localparam int L_ADD = 1;
  localparam int L_SHF = 8;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req [4];

  logic       d_ack1, d_ack2, d_ack3, d_ack4;
  logic [3:0] d_a1_cmd, d_a2_cmd;
  logic [1:0] d_a1_id, d_a2_id, d_a1_oid, d_a2_oid, d_inv_id;
  logic       d_a1_ov, d_a2_ov, d_inv_vld;

  logic       l_ack1, l_ack2, l_ack3, l_ack4;
  logic [3:0] l_a1_cmd, l_a2_cmd;
  logic [1:0] l_a1_id, l_a2_id, l_a1_oid, l_a2_oid, l_inv_id;
  logic       l_a1_ov, l_a2_ov, l_inv_vld;

  logic [3:0] d_ack;
  logic       mon_vld [4];
  logic [1:0] mon_id  [4];
  string      unames  [4] = '{"alu1_lat3", "alu2_lat3", "alu1_lat1", "alu2_lat8"};

  exp_t exp_q [4][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign d_ack = {d_ack4, d_ack3, d_ack2, d_ack1};
  assign mon_vld[0] = d_a1_ov;  assign mon_id[0] = d_a1_oid;
  assign mon_vld[1] = d_a2_ov;  assign mon_id[1] = d_a2_oid;
  assign mon_vld[2] = l_a1_ov;  assign mon_id[2] = l_a1_oid;
  assign mon_vld[3] = l_a2_ov;  assign mon_id[3] = l_a2_oid;

  calc1_dispatch_sched #(.ADD_LAT(D_ADD), .SHF_LAT(D_SHF)) dut (
    .c_clk(clk), .reset(rst_n),
    .req1_cmd_in(req[0]), .req2_cmd_in(req[1]), .req3_cmd_in(req[2]), .req4_cmd_in(req[3]),
    .prio_req1_ack(d_ack1), .prio_req2_ack(d_ack2), .prio_req3_ack(d_ack3), .prio_req4_ack(d_ack4),
    .prio_alu1_in_cmd(d_a1_cmd), .prio_alu1_in_req_id(d_a1_id),
    .prio_alu1_out_vld(d_a1_ov), .prio_alu1_out_req_id(d_a1_oid),
    .prio_alu2_in_cmd(d_a2_cmd), .prio_alu2_in_req_id(d_a2_id),
    .prio_alu2_out_vld(d_a2_ov), .prio_alu2_out_req_id(d_a2_oid),
    .prio_inv_vld(d_inv_vld), .prio_inv_req_id(d_inv_id)
  );

  calc1_dispatch_sched #(.ADD_LAT(L_ADD), .SHF_LAT(L_SHF)) dut_lat (
    .c_clk(clk), .reset(rst_n),
    .req1_cmd_in(req[0]), .req2_cmd_in(req[1]), .req3_cmd_in(req[2]), .req4_cmd_in(req[3]),
    .prio_req1_ack(l_ack1), .prio_req2_ack(l_ack2), .prio_req3_ack(l_ack3), .prio_req4_ack(l_ack4),
    .prio_alu1_in_cmd(l_a1_cmd), .prio_alu1_in_req_id(l_a1_id),
    .prio_alu1_out_vld(l_a1_ov), .prio_alu1_out_req_id(l_a1_oid),
    .prio_alu2_in_cmd(l_a2_cmd), .prio_alu2_in_req_id(l_a2_id),
    .prio_alu2_out_vld(l_a2_ov), .prio_alu2_out_req_id(l_a2_oid),
    .prio_inv_vld(l_inv_vld), .prio_inv_req_id(l_inv_id)
  );

  // Queue the expected result of an adder dispatch at the coming edge.
  task automatic exp_alu1(input logic [1:0] id);
    exp_t e;
    e.id = id; e.cyc = cyc + 1 + D_ADD; exp_q[0].push_back(e);
    e.cyc = cyc + 1 + L_ADD;            exp_q[2].push_back(e);
  endtask

  // Queue the expected result of a shifter dispatch at the coming edge.
  task automatic exp_alu2(input logic [1:0] id);
    exp_t e;
    e.id = id; e.cyc = cyc + 1 + D_SHF; exp_q[1].push_back(e);
    e.cyc = cyc + 1 + L_SHF;            exp_q[3].push_back(e);
  endtask

  // Advance one clock, sample #1 after the edge and score every result port.
  task automatic tick();
    bit   exp_v;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 4; u++) begin
      exp_v = (exp_q[u].size() != 0) && (exp_q[u][0].cyc == cyc);
      if (exp_v || (mon_vld[u] === 1'b1)) begin
        checks++;
        if (mon_vld[u] !== exp_v) begin
          errors++;
          $display("FAIL %s_out_vld cyc %0d got %b want %b", unames[u], cyc, mon_vld[u], exp_v);
        end else if (exp_v) begin
          e = exp_q[u].pop_front();
          if (mon_id[u] !== e.id) begin
            errors++;
            $display("FAIL %s_out_req_id cyc %0d got %0d want %0d", unames[u], cyc, mon_id[u], e.id);
          end
        end
      end
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) req[i] = 4'd0;
    repeat (3) tick();
    checks++;
    if ({d_ack, d_a1_cmd, d_a1_id, d_a2_cmd, d_a2_id, d_a1_ov, d_a1_oid,
         d_a2_ov, d_a2_oid, d_inv_vld, d_inv_id} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {d_ack, d_a1_cmd, d_a1_id, d_a2_cmd,
               d_a2_id, d_a1_ov, d_a1_oid, d_a2_ov, d_a2_oid, d_inv_vld, d_inv_id});
    end
    checks++;
    if ({l_a1_ov, l_a2_ov, l_inv_vld, l_ack1, l_ack2, l_ack3, l_ack4} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs_lat got %b want 0",
               {l_a1_ov, l_a2_ov, l_inv_vld, l_ack1, l_ack2, l_ack3, l_ack4});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req[1] = 4'd1;
    exp_alu1(2'd1);
    tick();
    checks++;
    if (d_ack !== 4'b0010) begin
      errors++; $display("FAIL single_ack got %b want 0010", d_ack);
    end
    checks++;
    if ({d_a1_cmd, d_a1_id, d_a2_cmd, d_inv_vld} !== {4'd1, 2'd1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_grant got %h/%h/%h/%b want 1/1/0/0", d_a1_cmd, d_a1_id, d_a2_cmd, d_inv_vld);
    end
    req[1] = 4'd0;
    tick();
    checks++;
    if ({d_ack, d_a1_cmd} !== 8'd0) begin
      errors++; $display("FAIL single_one_cycle got %h want 0", {d_ack, d_a1_cmd});
    end
    drain(12);
  endtask

  task automatic test_parallel();
    req[0] = 4'd2;
    req[2] = 4'd6;
    exp_alu1(2'd0);
    exp_alu2(2'd2);
    tick();
    checks++;
    if (d_ack !== 4'b0101) begin
      errors++; $display("FAIL parallel_ack got %b want 0101", d_ack);
    end
    checks++;
    if ({d_a1_cmd, d_a1_id, d_a2_cmd, d_a2_id} !== {4'd2, 2'd0, 4'd6, 2'd2}) begin
      errors++;
      $display("FAIL parallel_grant got %h/%h/%h/%h want 2/0/6/2", d_a1_cmd, d_a1_id, d_a2_cmd, d_a2_id);
    end
    req[0] = 4'd0;
    req[2] = 4'd0;
    drain(12);
  endtask

  task automatic test_invalid();
    req[3] = 4'd7;
    req[1] = 4'd15;
    tick();
    checks++;
    if ({d_inv_vld, d_inv_id, d_ack, d_a1_cmd, d_a2_cmd} !== {1'b1, 2'd1, 4'b0010, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL invalid_first got vld %b id %0d ack %b cmds %h/%h want 1 1 0010 0/0",
               d_inv_vld, d_inv_id, d_ack, d_a1_cmd, d_a2_cmd);
    end
    req[1] = 4'd0;
    tick();
    checks++;
    if ({d_inv_vld, d_inv_id, d_ack, d_a1_cmd, d_a2_cmd} !== {1'b1, 2'd3, 4'b1000, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL invalid_second got vld %b id %0d ack %b cmds %h/%h want 1 3 1000 0/0",
               d_inv_vld, d_inv_id, d_ack, d_a1_cmd, d_a2_cmd);
    end
    req[3] = 4'd0;
    tick();
    checks++;
    if ({d_inv_vld, d_ack} !== 5'd0) begin
      errors++; $display("FAIL invalid_idle got %b want 0", {d_inv_vld, d_ack});
    end
    drain(4);
  endtask

  task automatic test_midflight_reset();
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) req[i] = (i == n) ? 4'd1 : 4'd0;
      // Only the short-latency adder finishes the first two before reset.
      if (n < 2) begin
        e.id = 2'(n); e.cyc = cyc + 1 + L_ADD; exp_q[2].push_back(e);
      end
      tick();
      checks++;
      if ({d_ack, d_a1_cmd, d_a1_id} !== {4'(4'b0001 << n), 4'd1, 2'(n)}) begin
        errors++;
        $display("FAIL midflight_grant%0d got %b/%h/%0d want %b/1/%0d",
                 n, d_ack, d_a1_cmd, d_a1_id, 4'(4'b0001 << n), n);
      end
    end
    for (int i = 0; i < 4; i++) req[i] = 4'd0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({d_ack, d_a1_cmd, d_a1_ov} !== 9'd0) begin
      errors++; $display("FAIL midflight_reset_state got %h want 0", {d_ack, d_a1_cmd, d_a1_ov});
    end
    rst_n = 1'b1;
    drain(12);
  endtask

  task automatic test_back_to_back(input logic [3:0] cmd_even, input logic [3:0] cmd_odd,
                                   input bit to_alu2);
    logic [1:0] p;
    logic [3:0] want_cmd;
    logic [3:0] got_cmd;
    logic [1:0] got_id;
    logic [3:0] other_cmd;
    for (int i = 0; i < 4; i++) req[i] = (i % 2 == 0) ? cmd_even : cmd_odd;
    for (int n = 0; n < 8; n++) begin
      p = 2'(n % 4);
      want_cmd = p[0] ? cmd_odd : cmd_even;
      if (to_alu2) exp_alu2(p); else exp_alu1(p);
      tick();
      got_cmd   = to_alu2 ? d_a2_cmd : d_a1_cmd;
      got_id    = to_alu2 ? d_a2_id  : d_a1_id;
      other_cmd = to_alu2 ? d_a1_cmd : d_a2_cmd;
      checks++;
      if (d_ack !== (4'b0001 << p)) begin
        errors++; $display("FAIL rr_ack step %0d got %b want %b", n, d_ack, 4'b0001 << p);
      end
      checks++;
      if ({got_cmd, got_id, other_cmd} !== {want_cmd, p, 4'd0}) begin
        errors++;
        $display("FAIL rr_grant step %0d got %h/%0d/%h want %h/%0d/0", n, got_cmd, got_id,
                 other_cmd, want_cmd, p);
      end
    end
    for (int i = 0; i < 4; i++) req[i] = 4'd0;
    drain(12);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req[i] = 4'd0;
    test_reset();
    test_single();
    test_parallel();
    test_invalid();
    test_midflight_reset();
    test_back_to_back(4'd1, 4'd2, 1'b0);
    test_back_to_back(4'd5, 4'd5, 1'b1);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (exp_q[u].size() != 0) begin
        errors++;
        $display("FAIL %s_missing got %0d pending want 0", unames[u], exp_q[u].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc1_dispatch_sched.md
# calc1_dispatch_sched

Command scheduler for the calc1 engine. It arbitrates the four requester command ports onto the two shared execution units: the adder (ALU1) and the shifter (ALU2). It tracks each dispatched operation through the unit's fixed latency and emits result-valid/requester-ID to the output stages. It also answers invalid commands directly.

## Interface
Parameters:
- ADD_LAT, default 3: adder latency, from dispatch cycle to result cycle; legal 1..8.
- SHF_LAT, default 3: shifter latency; legal 1..8.

Ports:
- c_clk  in  1  functional clock; all state on rising edge.
- reset  in  1  **one clock; reset is synchronous and active-low.** Low at an edge clears all state.
- req1_cmd_in .. req4_cmd_in  in  [0:3] each  per-port command; nonzero means a request; held until acked.
- prio_req1_ack .. prio_req4_ack  out  1 each  one-cycle grant pulse for the port.
- prio_alu1_in_cmd  out  [0:3]  command to the adder; 0 when idle.
- prio_alu1_in_req_id  out  [0:1]  granted port minus 1.
- prio_alu1_out_vld  out  1  adder result valid this cycle.
- prio_alu1_out_req_id  out  [0:1]  owner of the adder result.
- prio_alu2_in_cmd, prio_alu2_in_req_id, prio_alu2_out_vld, prio_alu2_out_req_id: same as ALU1, for the shifter.
- prio_inv_vld  out  1  invalid-command response valid.
- prio_inv_req_id  out  [0:1]  owner of the invalid command.

## Operation
- Command decode:
  - 0 = NOP.
  - 1 = ADD and 2 = SUB go to ALU1.
  - 5 = SHL and 6 = SHR go to ALU2.
  - Every other value is invalid.
- Eligibility: a port is eligible when its cmd is nonzero and its ack is not currently high. The one-cycle ack mask prevents a stale re-grant.
- Arbitration per unit:
  - Independent 4-way round-robin among eligible ports whose command targets that unit.
  - Pointer resets to port 1.
  - After granting port k, the pointer moves to k+1 (port 4 wraps to port 1).
  - The pointer is unchanged when there is no grant.
- ALU1 and ALU2 may grant different ports in the same cycle. One port is never granted by both, since each command targets one unit.
- Invalid path:
  - Fixed priority, lowest port number first; one per cycle.
  - Acks the port and asserts prio_inv_vld with its ID.
  - Other invalid ports wait.
- Tracking: each unit has a LAT-deep valid/ID shift pipeline. Every dispatch enters it, and pipelines never stall.
- Reset values:
  - All acks, in_cmd, in_req_id, out_vld, out_req_id, prio_inv_vld and prio_inv_req_id are 0.
  - Pipelines are flushed and pointers return to port 1.
- Reset mid-operation: in-flight operations are dropped with no out_vld. The first grant is possible at the first edge with reset high.

## Timing
- Inputs are sampled at edge E0.
- Grant outputs (ack, in_cmd, in_req_id, inv) are registered and high for exactly cycle C1, which follows E0.
- Result outputs: aluX_out_vld and out_req_id are high for exactly one cycle, C1+LAT.
- Requester handshake: on seeing ack in C1, the requester must drop or replace its cmd at edge E1. The port is masked at E1, so it is grantable again at E2 at the earliest.
- Maximum per-port throughput is one grant per 2 cycles. Maximum per-unit throughput is one dispatch per cycle.
- Back-to-back dispatches yield back-to-back out_vld in the same order. There is no reordering within a unit.
- Results of the two units are independent. Equal latencies can produce both out_vld in the same cycle.

## Structure
- Shared calc1_defs package/include holds:
  - command encodings CMD_NOP/ADD/SUB/SHL/SHR;
  - unit-select decode function;
  - response codes (success 01, invalid 10) for the output stage.
- One sub-module, calc1_rr_arb: 4-bit request vector in, one-hot grant and 2-bit ID out, pointer state inside. Instantiated twice, once for ALU1 and once for ALU2.
- The top level holds decode, masks, the invalid priority encoder, and the two latency pipelines.
- Expected size is about 200–300 lines total.

## Test plan
- Reset and single op: hold reset low 3 cycles → all outputs 0. Then req2_cmd_in=1 at E0 → prio_req2_ack and prio_alu1_in_cmd=1, in_req_id=01 in C1; prio_alu1_out_vld with out_req_id=01 in C4 (ADD_LAT=3).
- Round-robin fairness: all four ports hold cmd=5 continuously, replacing it after each ack → ALU2 grants in order 1,2,3,4,1… with in_cmd=5 every cycle; no port is granted in consecutive cycles.
- Parallel units: req1=2, req3=6 at the same edge → both acked in C1; alu1_in_req_id=00 and alu2_in_req_id=10; both out_vld in C4.
- Invalid commands: req4=7 and req2=15 at the same edge → C1: prio_inv_vld, ID=01 (port 2), ack2. C2: inv ID=11 (port 4), ack4. No ALU activity.
- Mid-flight reset: dispatch 3 adds in consecutive cycles, then pull reset low one cycle before the first result → no prio_alu1_out_vld ever asserts; pointer at port 1 afterwards.
- Latency parameters: ADD_LAT=1 and SHF_LAT=8 → out_vld in C2 and C9 respectively; req_id order preserved under continuous traffic.
